// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Width codes follow the RV32I load/store func3 encoding.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Unsigned widths only make sense for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_extract.sv
// Selects the addressed byte/half/word of a storage word and extends it
// according to the load width code.
module dmem_load_extract
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    result   = '0;
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    case (func3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_W:    result = word;
      F3_BU:   result = {24'b0, byte_sel};
      F3_HU:   result = {16'b0, half_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory with a fixed wait-state valid/ready responder.
// DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses error instead of being aligned down.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// WAIT    | request captured, counting down wait states
// RESP    | first cycle: access memory; then hold response until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [AW+1:0]         cap_addr;
  logic [31:0]           cap_wdata;
  logic                  cap_we;
  logic [2:0]            cap_func3;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, access, mem_we, acc_err;
  logic [1:0]    eff_lo;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata, rd_word, ld_result;
  logic [AW-1:0] word_idx;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign req_ready = rst && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign access    = (state_q == ST_RESP) && !rsp_valid;
  assign word_idx  = cap_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == WAIT_CNT_W'(1)) state_d = ST_RESP;
      ST_RESP: if (rsp_valid && rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eff_lo  = cap_addr[1:0];
    acc_err = f3_illegal(cap_func3, cap_we);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((cap_func3 == F3_H || cap_func3 == F3_HU) && cap_addr[0]) acc_err = 1'b1;
    if (cap_func3 == F3_W && cap_addr[1:0] != 2'b00) acc_err = 1'b1;
`else
    if (cap_func3 == F3_H || cap_func3 == F3_HU) eff_lo[0] = 1'b0;
    if (cap_func3 == F3_W) eff_lo = 2'b00;
`endif
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = cap_wdata;
    case (cap_func3)
      F3_B: begin
        lane_be    = 4'b0001 << eff_lo;
        lane_wdata = {4{cap_wdata[7:0]}};
      end
      F3_H: begin
        lane_be    = eff_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{cap_wdata[15:0]}};
      end
      F3_W:    lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  end

  assign mem_we  = rst && access && cap_we && !acc_err;
  assign rd_word = mem[word_idx];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) mem[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
  end

  dmem_load_extract u_extract (
    .word    (rd_word),
    .addr_lo (eff_lo),
    .func3   (cap_func3),
    .result  (ld_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_we    <= 1'b0;
      cap_func3 <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_addr  <= req_addr[AW+1:0];
        cap_wdata <= req_wdata;
        cap_we    <= req_we;
        cap_func3 <= req_func3;
        cnt_q     <= WAIT_INIT;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (access) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (cap_we || acc_err) ? 32'h0 : ld_result;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYCLES = 2, DEPTH_WORDS = 1024).
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", tag);
  endtask

  // Present a request and return after the accepting edge.
  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, output logic ok);
    int guard;
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      timeout({tag, " accept"});
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     output logic [31:0] rdata, output logic err);
    int   lat;
    logic ok;
    rdata = '0;
    err   = 1'b1;
    issue(tag, we, f3, addr, wdata, ok);
    if (!ok) return;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      timeout({tag, " rsp"});
      return;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, " hold rdata"}, rsp_rdata, rdata);
      check({tag, " hold req_ready"}, {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " valid drop"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, " ready back"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic ok;
    int   guard;

    repeat (3) @(negedge clk);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset req_ready", {31'b0, req_ready}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    rst = 1'b1;
    #1 check("post reset req_ready", {31'b0, req_ready}, 32'd1);

    txn("sw10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("sw10 err", {31'b0, er}, 32'd0);
    check("sw10 rdata", rd, 32'h0);
    txn("lw10", 1'b0, F3_W, 32'h10, 32'h0, 0, rd, er);
    check("lw10 rdata", rd, 32'hDEADBEEF);
    check("lw10 err", {31'b0, er}, 32'd0);

    txn("sb13", 1'b1, F3_B, 32'h13, 32'h12345680, 0, rd, er);
    txn("lb13", 1'b0, F3_B, 32'h13, 32'h0, 0, rd, er);
    check("lb13 rdata", rd, 32'hFFFFFF80);
    txn("lbu13", 1'b0, F3_BU, 32'h13, 32'h0, 0, rd, er);
    check("lbu13 rdata", rd, 32'h00000080);
    txn("lh12", 1'b0, F3_H, 32'h12, 32'h0, 0, rd, er);
    check("lh12 rdata", rd, 32'hFFFF80AD);
    txn("lhu10", 1'b0, F3_HU, 32'h10, 32'h0, 0, rd, er);
    check("lhu10 rdata", rd, 32'h0000BEEF);

    txn("lw10 hold", 1'b0, F3_W, 32'h10, 32'h0, 5, rd, er);
    check("lw10 hold rdata", rd, 32'h80ADBEEF);

    txn("sh12", 1'b1, F3_H, 32'h12, 32'hABCD1234, 0, rd, er);
    txn("lw10 sh", 1'b0, F3_W, 32'h10, 32'h0, 0, rd, er);
    check("lw10 after sh", rd, 32'h1234BEEF);

    txn("sw20", 1'b1, F3_W, 32'h20, 32'hA5A5A5A5, 0, rd, er);
    txn("s011", 1'b1, 3'b011, 32'h20, 32'h12345678, 0, rd, er);
    check("s011 err", {31'b0, er}, 32'd1);
    check("s011 rdata", rd, 32'h0);
    txn("sbu", 1'b1, F3_BU, 32'h20, 32'h000000FF, 0, rd, er);
    check("sbu err", {31'b0, er}, 32'd1);
    txn("l111", 1'b0, 3'b111, 32'h20, 32'h0, 0, rd, er);
    check("l111 err", {31'b0, er}, 32'd1);
    check("l111 rdata", rd, 32'h0);
    txn("lw20", 1'b0, F3_W, 32'h20, 32'h0, 0, rd, er);
    check("lw20 unchanged", rd, 32'hA5A5A5A5);

    // Reset one cycle into WAIT must drop the store.
    txn("sw40", 1'b1, F3_W, 32'h40, 32'hCAFEF00D, 0, rd, er);
    issue("sw40 rst", 1'b1, F3_W, 32'h40, 32'h11111111, ok);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst wait rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst wait req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    #1 check("rst wait req_ready back", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("rst wait no rsp", {31'b0, rsp_valid}, 32'd0);
    txn("lw40", 1'b0, F3_W, 32'h40, 32'h0, 0, rd, er);
    check("lw40 old value", rd, 32'hCAFEF00D);

    // Reset while a response is pending drops it.
    issue("lw40 rst", 1'b0, F3_W, 32'h40, 32'h0, ok);
    guard = 0;
    while (ok && !rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) timeout("rst resp wait");
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst resp rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst resp rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b1;

    txn("sw00", 1'b1, F3_W, 32'h0, 32'h0BADC0DE, 0, rd, er);
    txn("lw1002", 1'b0, F3_W, 32'h1002, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw1002 err", {31'b0, er}, 32'd1);
    check("lw1002 rdata", rd, 32'h0);
`else
    check("lw1002 err", {31'b0, er}, 32'd0);
    check("lw1002 rdata", rd, 32'h0BADC0DE);
`endif
    txn("lh11", 1'b0, F3_H, 32'h11, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lh11 err", {31'b0, er}, 32'd1);
`else
    check("lh11 rdata", rd, 32'hFFFFBEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  initiator presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port req_func3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was illegal; no memory side effect.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 IDLE: on req_valid & req_ready SHALL capture addr/wdata/we/func3, load wait counter with WAIT_CYCLES, go to WAIT (go directly to RESP if WAIT_CYCLES = 0).
REQ-017 WAIT: counter SHALL decrement each cycle; on counter = 1 go to RESP.
REQ-018 On the cycle of entering RESP, stores SHALL commit and load data SHALL be registered; rsp_valid rises exactly WAIT_CYCLES+1 cycles after accept.
REQ-019 RESP: rsp_valid, rsp_rdata, rsp_err SHALL hold stable until rsp_valid & rsp_ready; then return to IDLE with rsp_valid = 0 next cycle.
REQ-020 No request SHALL be accepted in the same cycle as a response handshake (minimum 1 idle cycle between transactions).
REQ-021 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap modulo 4*DEPTH_WORDS bytes).
REQ-022 Stores SHALL write only the addressed lanes: SB lane addr[1:0], SH lanes {addr[1],0}/{addr[1],1}, SW all four.
REQ-023 Loads SHALL extract addressed lane(s); B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-024 func3 in {011,110,111}, or BU/HU with req_we = 1, SHALL give rsp_err = 1, rsp_rdata = 0, no write.
REQ-025 Storage contents SHALL NOT be reset and SHALL be uninitialised-valid (X permitted in simulation).

Reset
REQ-026 While rst = 0 at a clock edge: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, captured fields 0.
REQ-027 req_ready SHALL be 0 while rst = 0.
REQ-028 Reset in WAIT SHALL discard the transaction; an uncommitted store SHALL NOT write.
REQ-029 Reset in RESP SHALL drop the pending response without handshake.

Configuration
REQ-030 Macro DMEM_MISALIGN_TRAP_EN defined: H/HU with addr[0] = 1, or W with addr[1:0] != 0, SHALL give rsp_err = 1, rsp_rdata = 0, no write.
REQ-031 Macro undefined: misaligned low address bits SHALL be forced to zero for that width (H clears addr[0], W clears addr[1:0]); rsp_err never set by alignment.

Structure
REQ-032 Package dmem_pkg SHALL hold func3 width constants, FSM state enum typedef, and WAIT counter width constant.
REQ-033 Load lane extraction/extension SHALL be a combinational sub-module dmem_load_extract (inputs word, addr[1:0], func3; output 32-bit result).

Verification (WAIT_CYCLES = 2, DEPTH_WORDS = 1024)
REQ-034 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0; rsp_valid exactly 3 cycles after each accept.
REQ-035 After REQ-034, SB 0x80 @0x13, LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80AD.
REQ-036 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0; accept on cycle 6, req_ready 1 following cycle.
REQ-037 func3 = 011 store 0x12345678 @0x20 -> rsp_err 1, rdata 0; subsequent LW @0x20 returns prior contents unchanged.
REQ-038 SW 0x11111111 @0x40, assert rst one cycle into WAIT -> no write (LW @0x40 returns old value), rsp_valid 0, req_ready 0 then 1.
REQ-039 LW @0x1002 -> with DMEM_MISALIGN_TRAP_EN rsp_err 1; without, returns word at 0x0000 (wrap + alignment), rsp_err 0.
